// File: rtl/mult_32.sv
// mult_32: sequential unsigned shift-add multiplier, one partial-product step
// per clock. A launch takes 32 steps; the 64-bit product is then published on
// the registered hi/lo pair together with a one-cycle done pulse.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset (aborts any operation)
//   hi, lo       upper/lower half of the last completed product
//   multiplier   operand A, captured at launch
//   multiplicand operand B, captured at launch
//   start        launch request, honoured only while idle
//   busy         high while an operation is in progress
//   done         one-cycle pulse when hi/lo receive a new result
module mult_32 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] multiplier,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic             start,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0]   m_reg;   // latched multiplicand
  logic [2*WIDTH:0]   p_reg;   // {carry, upper, lower}
  logic [CW-1:0]      count;
  logic               launch;
  logic               last;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH:0]   p_step;

  assign launch = (state == IDLE) && start;
  assign last   = (count == CW'(WIDTH - 1));

  // One step: conditional add into {carry, upper}, then shift the whole
  // working register right with a zero entering at the top. The carry bit is
  // always zero before the add (it was shifted out), so it can seed the sum.
  always_comb begin
    sum = p_reg[2*WIDTH:WIDTH];
    if (p_reg[0]) begin
      sum = sum + {1'b0, m_reg};
    end
    p_step = {1'b0, sum, p_reg[WIDTH-1:1]};
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start) state_next = RUN;
      RUN:  if (last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy = (state == RUN);
  end

  // Datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg <= '0;
      p_reg <= '0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
    end else begin
      done <= (state == RUN) && last;
      if (launch) begin
        m_reg <= multiplicand;
        p_reg <= {1'b0, {WIDTH{1'b0}}, multiplier};
        count <= '0;
      end else if (state == RUN) begin
        p_reg <= p_step;
        count <= count + CW'(1);
        if (last) begin
          hi <= p_step[2*WIDTH-1:WIDTH];
          lo <= p_step[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_32.sv
module tb_mult_32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] hi, lo;
  logic [31:0] multiplier = '0;
  logic [31:0] multiplicand = '0;
  logic        start = 1'b0;
  logic        busy, done;

  int unsigned passed = 0;
  int unsigned total  = 0;

  logic [63:0] sb[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  mult_32 #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .hi(hi), .lo(lo),
    .multiplier(multiplier), .multiplicand(multiplicand),
    .start(start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding result.
  always @(negedge clk) begin
    if (!rst && done) begin
      check("done_busy_exclusive", {63'd0, busy}, 64'd0);
      if (sb.size() == 0) begin
        check("done_unexpected", {63'd0, done}, 64'd0);
      end else begin
        check("sb_product", {hi, lo}, sb.pop_front());
      end
    end
  end

  // Counts edges until done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 60);
    if (!done) check("done_timeout", {63'd0, done}, 64'd1);
  endtask

  initial begin
    vec_t vecs[5];
    int n, n2;
    logic [63:0] acc;
    logic ok;
    logic seen;

    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[1] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};
    vecs[2] = '{32'h1234_5678, 32'h0000_0000, 64'h0};
    vecs[3] = '{32'hDEAD_BEEF, 32'h0123_4567, 64'(32'hDEAD_BEEF) * 64'(32'h0123_4567)};
    vecs[4] = '{32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF};

    // Reset state
    #12;
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 1*2 with start held high through the run
    multiplier = 32'd1; multiplicand = 32'd2; start = 1'b1;
    sb.push_back(64'd2);
    @(posedge clk); #1;
    acc = '0;
    for (int c = 1; c < 32; c++) begin
      @(posedge clk); #1;
      acc = acc | {hi, lo} | {63'd0, done};
    end
    check("hold_before_done", acc, 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("first_done_edge32", {63'd0, done}, 64'd1);
    check("first_lo", {32'd0, lo}, 64'd2);
    repeat (5) @(posedge clk);
    #1;
    check("result_held", {hi, lo}, 64'd2);
    check("done_one_cycle", {63'd0, done}, 64'd0);

    // Table-driven single-pulse launches
    for (int i = 0; i < 5; i++) begin
      multiplier = vecs[i].a; multiplicand = vecs[i].b; start = 1'b1;
      sb.push_back(vecs[i].exp);
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(n);
      check($sformatf("vec%0d_latency", i), 64'(n), 64'd32);
      check($sformatf("vec%0d_product", i), {hi, lo}, vecs[i].exp);
      @(posedge clk); #1;
    end

    // Operand change and start pulse during RUN must be ignored
    multiplier = 32'd3; multiplicand = 32'd5; start = 1'b1;
    sb.push_back(64'd15);
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b1;
    for (int c = 1; c < 32; c++) begin
      if (c == 9) begin
        multiplier = 32'd7; multiplicand = 32'd9; start = 1'b1;
      end
      @(posedge clk); #1;
      if (c == 10) start = 1'b0;
      if (!busy || done) ok = 1'b0;
    end
    start = 1'b0;
    check("busy_full_run", {63'd0, ok}, 64'd1);
    @(posedge clk); #1;
    check("ignore_done", {63'd0, done}, 64'd1);
    check("ignore_product", {hi, lo}, 64'd15);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("no_restart", {63'd0, seen}, 64'd0);

    // Reset mid-run aborts without a done pulse
    multiplier = 32'hFFFF_FFFF; multiplicand = 32'd2; start = 1'b1;
    sb.push_back(64'h1_FFFF_FFFE);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_hi", {32'd0, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    sb.delete();
    #3;
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("abort_no_done", {63'd0, seen}, 64'd0);

    // Back-to-back with start held high
    multiplier = 32'd6; multiplicand = 32'd7; start = 1'b1;
    sb.push_back(64'd42);
    @(posedge clk); #1;
    multiplier = 32'd100000; multiplicand = 32'd100000;
    sb.push_back(64'h0000_0002_540B_E400);
    wait_done(n);
    check("b2b_first_latency", 64'(n), 64'd32);
    check("b2b_first_lo", {32'd0, lo}, 64'd42);
    wait_done(n2);
    start = 1'b0;
    check("b2b_period", 64'(n2), 64'd33);
    check("b2b_second", {hi, lo}, 64'h0000_0002_540B_E400);
    repeat (40) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
